uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Parametrised UART transmitter with a valid/ready input stream, a transmit FIFO, and configurable frame format: data width, parity and stop bits. It replaces the single-byte, start-pulse transmitter on the board's GPIO TX pin. The redstone simulation core and host-link logic can queue output bytes without waiting for each frame to finish.

## Interface
Parameters:
- CLKS_PER_BIT, 434 — i_clk cycles per UART bit; minimum 2 (434 gives 115200 baud at 50 MHz).
- DATA_BITS, 8 — data bits per frame, 5..9.
- PARITY, 0 — 0 none, 1 odd, 2 even.
- STOP_BITS, 1 — 1 or 2.
- FIFO_DEPTH, 16 — entries; power of two, at least 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  producer has a byte on i_data.
- i_data  in  DATA_BITS  byte to send; only the low DATA_BITS bits are used.
- o_ready  out  1  FIFO can accept a byte; reset value 1.
- o_tx  out  1  serial line; idles high; reset value 1.
- o_busy  out  1  a frame is being shifted; reset value 0.
- o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; reset value 0.

## Operation
- Accept a byte when i_valid && o_ready on a rising edge. The byte is written to the FIFO tail.
- o_ready = (o_count != FIFO_DEPTH). It is registered and depends only on state, never combinationally on i_valid.
- Push and pop on the same edge: o_count is unchanged. If the FIFO is full, a push is refused even when a pop occurs that cycle.
- FSM states:
  - IDLE: o_tx=1, o_busy=0. Go to LOAD when the FIFO is non-empty.
  - LOAD: pop the head into the shift register, compute parity, go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: skipped when PARITY=0.
    - Odd parity: the bit makes the count of 1s across data+parity odd.
    - Even parity: the bit makes that count even.
  - STOP: o_tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - After STOP: go to LOAD if the FIFO is non-empty, else IDLE.
- o_busy is 1 in every state except IDLE.
- The bit timer counts 0..CLKS_PER_BIT-1. It is sized $clog2(CLKS_PER_BIT). It wraps to 0 at each bit boundary.
- The FIFO read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Asserting i_rst at any time, including mid-frame:
  - o_tx goes to 1 and o_busy to 0 immediately.
  - The FIFO is emptied.
  - The FSM returns to IDLE.
  - The partial frame is abandoned with no completion.

## Timing
- o_tx is driven from a flop, so the line is glitch-free.
- A byte accepted at edge N with the FIFO empty and the FSM in IDLE:
  - edge N+1: FSM enters LOAD, o_count=1.
  - edge N+2: FSM enters START, o_tx=0 (start bit), o_count=0.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames insert exactly one LOAD cycle of o_tx=1 between the last stop bit and the next start bit.
- Sustained throughput: one accepted byte per frame period. Bursts are absorbed up to FIFO_DEPTH bytes.

## Configuration
- UART_TX_FIFO_EN defined:
  - The FIFO is FIFO_DEPTH entries as described above.
- UART_TX_FIFO_EN undefined:
  - The FIFO is replaced by a single holding register and FIFO_DEPTH is ignored.
  - o_count is 0 or 1.
  - o_ready=0 while the holding register is full.
  - A new byte can be accepted during the current frame once LOAD has emptied the register.
  - Frame timing is identical.

## Test plan
- Reset, then idle: after i_rst releases, o_tx=1, o_busy=0, o_ready=1, o_count=0 for 100 cycles with no i_valid.
- Single byte (CLKS_PER_BIT=4, 8N1): push 0xA5.
  - o_tx falls 2 edges later.
  - Per 4-cycle bit it then carries 0,1,0,1,0,0,1,0,1,1.
  - o_busy drops after 40+1 cycles.
- Parity and stop bits (PARITY=2, STOP_BITS=2): send 0xA5 then 0x01.
  - 0xA5 has parity bit 0 and 0x01 has parity bit 1.
  - Each frame is 12 bits; the gap between frames is exactly 1 cycle high.
- FIFO full (FIFO_DEPTH=4): hold i_valid with values 0x10..0x15.
  - o_ready drops after the 4 bytes still in the FIFO (plus the 1 already popped into the shift register).
  - Bytes are sent strictly in order 0x10..0x15 with none lost or duplicated.
- Simultaneous push and pop: at count=2, push on the LOAD edge.
  - o_count stays 2.
- Reset mid-frame: assert i_rst during DATA bit 3.
  - o_tx=1 and o_count=0 are seen asynchronously, before the next edge.
  - After release, no residual frame is sent.
  - A fresh 0x3C is sent correctly.

Source files
------------

// File: rtl/uart_tx_stream.sv
// uart_tx_stream
//   UART transmitter fed by a valid/ready byte stream. Bytes are queued and
//   shifted out LSB first with a configurable frame format:
//   start bit, DATA_BITS data bits, optional parity bit, STOP_BITS stop bits.
//
//   Build option UART_TX_FIFO_EN:
//     defined   - FIFO_DEPTH-entry transmit FIFO.
//     undefined - single holding register; o_count is 0 or 1 and
//                 FIFO_DEPTH only sets the width of o_count.
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-low reset
//   i_valid  producer has a byte on i_data
//   i_data   byte to send (DATA_BITS wide)
//   o_ready  queue can accept a byte (registered)
//   o_tx     serial line, idles high (registered)
//   o_busy   a frame is in progress (registered)
//   o_count  queue occupancy
//
// FSM states:
//   state    | meaning
//   S_IDLE   | line high, waiting for a queued byte
//   S_LOAD   | pop head into shifter, latch parity (line still high)
//   S_START  | start bit, line low
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (never entered when PARITY = 0)
//   S_STOP   | STOP_BITS stop bits, line high

module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic [DATA_BITS-1:0]          i_data,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  logic [TW-1:0]          timer;
  logic [BW-1:0]          bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shifter;
  logic                   par_bit;

  logic                   push;
  logic                   pop;
  logic                   not_empty;
  logic [DATA_BITS-1:0]   head_data;

  // o_ready is a flop, so a full queue refuses a push even on a popping edge.
  assign push      = i_valid && o_ready;
  assign pop       = (state == S_LOAD);
  assign not_empty = (o_count != '0);

`ifdef UART_TX_FIFO_EN

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_next;

  always_comb begin
    count_next = o_count;
    if (push && !pop) begin
      count_next = o_count + CW'(1);
    end else if (pop && !push) begin
      count_next = o_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      o_count <= count_next;
      o_ready <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset: occupancy alone says which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  assign head_data = mem[rd_ptr];

`else

  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic                 full_next;

  assign full_next = (hold_full & ~pop) | push;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      o_ready   <= 1'b1;
    end else begin
      if (push) begin
        hold_data <= i_data;
      end
      hold_full <= full_next;
      o_ready   <= ~full_next;
    end
  end

  assign o_count   = CW'(hold_full);
  assign head_data = hold_data;

`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shifter  <= '0;
      par_bit  <= 1'b0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_tx <= 1'b1;
          if (not_empty) begin
            state  <= S_LOAD;
            o_busy <= 1'b1;
          end
        end

        S_LOAD: begin
          shifter  <= head_data;
          // odd: bit set when data has an even number of ones
          par_bit  <= (PARITY == 1) ? ~^head_data : ^head_data;
          timer    <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          o_tx     <= 1'b0;
          state    <= S_START;
        end

        S_START: begin
          if (timer == T_LAST) begin
            timer <= '0;
            o_tx  <= shifter[0];
            state <= S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_DATA: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (bit_idx == B_LAST) begin
              if (PARITY != 0) begin
                o_tx  <= par_bit;
                state <= S_PARITY;
              end else begin
                o_tx  <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              shifter <= shifter >> 1;
              o_tx    <= shifter[1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_PARITY: begin
          if (timer == T_LAST) begin
            timer <= '0;
            o_tx  <= 1'b1;
            state <= S_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_STOP: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (stop_idx == STOP_LAST) begin
              // Back-to-back frames pass through one LOAD cycle, line high.
              if (not_empty) begin
                state <= S_LOAD;
              end else begin
                state  <= S_IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state  <= S_IDLE;
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Testbench for uart_tx_stream.
// Two instances share clock and reset:
//   dut_a : CLKS_PER_BIT=4, 8N1, FIFO_DEPTH=4
//   dut_b : CLKS_PER_BIT=4, 8E2, FIFO_DEPTH=4
// Expected frames (bit 0 = start bit) are queued when a byte is accepted;
// a line monitor rebuilds each frame from o_tx and compares against the queue.

module tb_uart_tx_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;

  logic       o_ready_a, o_tx_a, o_busy_a;
  logic       o_ready_b, o_tx_b, o_busy_b;
  logic [2:0] o_count_a, o_count_b;

  always #5 clk = ~clk;

  uart_tx_stream #(
    .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .i_data(data_a),
    .o_ready(o_ready_a), .o_tx(o_tx_a), .o_busy(o_busy_a), .o_count(o_count_a)
  );

  uart_tx_stream #(
    .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .i_data(data_b),
    .o_ready(o_ready_b), .o_tx(o_tx_b), .o_busy(o_busy_b), .o_count(o_count_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] exp_q [2][$];

  int   cyc = 0;
  int   cyc_p = 0;
  int   last_acc = 0;
  int   st_last [2] = '{0, 0};
  int   st_prev [2] = '{0, 0};
  logic act [2] = '{1'b0, 1'b0};
  logic prev [2] = '{1'b1, 1'b1};
  int   pos [2] = '{0, 0};
  logic [11:0] got [2] = '{12'h000, 12'h000};

  task automatic chk(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic tx_of(input int d);
    return (d == 0) ? o_tx_a : o_tx_b;
  endfunction

  function automatic logic rdy_of(input int d);
    return (d == 0) ? o_ready_a : o_ready_b;
  endfunction

  function automatic int cnt_of(input int d);
    return (d == 0) ? int'(o_count_a) : int'(o_count_b);
  endfunction

  function automatic int nbits(input int d);
    return (d == 0) ? 10 : 12;
  endfunction

  always @(posedge clk) cyc_p++;

  // Line monitor: samples each bit in its third clock, compares whole frames.
  always @(negedge clk) begin : monitor
    logic [11:0] e;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        act[d] = 1'b0;
      end else if (!act[d]) begin
        if (prev[d] && !tx_of(d)) begin
          act[d]     = 1'b1;
          pos[d]     = 0;
          got[d]     = '0;
          st_prev[d] = st_last[d];
          st_last[d] = cyc;
        end
      end else begin
        pos[d]++;
      end
      if (act[d] && rst) begin
        if (pos[d] % 4 == 2) got[d][pos[d] / 4] = tx_of(d);
        if (pos[d] == nbits(d) * 4 - 1) begin
          act[d] = 1'b0;
          if (exp_q[d].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame dut%0d: got 0x%0h, required no frame", d, got[d]);
          end else begin
            e = exp_q[d].pop_front();
            chk($sformatf("frame_dut%0d", d), int'(got[d]), int'(e));
          end
        end
      end
      prev[d] = rst ? tx_of(d) : 1'b1;
    end
  end

  // Present a byte at a negedge, hold valid until accepted; returns with
  // valid still high, #1 after the accepting edge.
  task automatic push(input int d, input logic [7:0] b, input logic [11:0] frame,
                      output int waited, output int cnt);
    waited = 0;
    cnt    = 0;
    @(negedge clk);
    if (d == 0) begin valid_a = 1'b1; data_a = b; end
    else        begin valid_b = 1'b1; data_b = b; end
    while (!rdy_of(d) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy_of(d)) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: got ready=0, required ready=1", d);
    end else begin
      exp_q[d].push_back(frame);
      @(posedge clk);
      #1;
      cnt      = cnt_of(d);
      last_acc = cyc_p;
    end
  endtask

  task automatic wait_drain(input int d);
    int t = 0;
    while (exp_q[d].size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("drain_dut%0d", d), exp_q[d].size(), 0);
  endtask

`ifdef UART_TX_FIFO_EN
  int exp_cnt [6] = '{1, 2, 2, 3, 4, 4};
  int exp_burst = 5;
`else
  int exp_cnt [6] = '{1, 1, 1, 1, 1, 1};
  int exp_burst = 1;
`endif

  initial begin : stim
    int w, c, bad_a, bad_b, first_stall, acc55, low_cnt;
    logic [7:0] b;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_a",    int'(o_tx_a),    1);
    chk("rst_busy_a",  int'(o_busy_a),  0);
    chk("rst_ready_a", int'(o_ready_a), 1);
    chk("rst_count_a", int'(o_count_a), 0);
    chk("rst_tx_b",    int'(o_tx_b),    1);
    chk("rst_ready_b", int'(o_ready_b), 1);
    rst = 1'b1;

    // idle for 100 cycles
    bad_a = 0;
    bad_b = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_tx_a !== 1'b1 || o_busy_a !== 1'b0 || o_ready_a !== 1'b1 || o_count_a !== 3'd0) bad_a++;
      if (o_tx_b !== 1'b1 || o_busy_b !== 1'b0 || o_ready_b !== 1'b1 || o_count_b !== 3'd0) bad_b++;
    end
    chk("idle_bad_cycles_a", bad_a, 0);
    chk("idle_bad_cycles_b", bad_b, 0);

    // single byte 0xA5, 8N1: line 0,1,0,1,0,0,1,0,1,1
    push(0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, w, c);
    valid_a = 1'b0;
    chk("sb_count_acc", c, 1);
    @(posedge clk); #1;
    chk("sb_load_tx",    int'(o_tx_a),    1);
    chk("sb_load_busy",  int'(o_busy_a),  1);
    chk("sb_load_count", int'(o_count_a), 1);
    @(posedge clk); #1;
    chk("sb_start_tx",    int'(o_tx_a),    0);
    chk("sb_start_count", int'(o_count_a), 0);
    repeat (39) @(posedge clk);
    #1;
    chk("sb_busy_last", int'(o_busy_a), 1);
    @(posedge clk); #1;
    chk("sb_busy_end", int'(o_busy_a), 0);
    wait_drain(0);

    // 8E2: 0xA5 -> parity 0, 0x01 -> parity 1, one-cycle gap between frames
    push(1, 8'hA5, {2'b11, 1'b0, 8'hA5, 1'b0}, w, c);
    push(1, 8'h01, {2'b11, 1'b1, 8'h01, 1'b0}, w, c);
    valid_b = 1'b0;
    wait_drain(1);
    chk("b2b_start_spacing", st_last[1] - st_prev[1], 12 * 4 + 1);

    // burst 0x10..0x15 with valid held; includes push on a LOAD edge
    first_stall = -1;
    for (int i = 0; i < 6; i++) begin
      b = 8'h10 + 8'(i);
      push(0, b, {2'b00, 1'b1, b, 1'b0}, w, c);
      if (w != 0 && first_stall < 0) first_stall = i;
      chk($sformatf("burst_count_%0d", i), c, exp_cnt[i]);
    end
    valid_a = 1'b0;
    chk("burst_len_before_stall", first_stall, exp_burst);
    wait_drain(0);

    // reset during data bit 3 of 0x55 (bit 3 = 0), with 0x66 queued
    push(0, 8'h55, {2'b00, 1'b1, 8'h55, 1'b0}, w, c);
    acc55 = last_acc;
    push(0, 8'h66, {2'b00, 1'b1, 8'h66, 1'b0}, w, c);
    valid_a = 1'b0;
    while (cyc_p < acc55 + 19) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_tx",    int'(o_tx_a),    0);
    chk("pre_rst_count", int'(o_count_a), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_tx",    int'(o_tx_a),    1);
    chk("async_rst_count", int'(o_count_a), 0);
    chk("async_rst_busy",  int'(o_busy_a),  0);
    exp_q[0].delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    low_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (o_tx_a !== 1'b1) low_cnt++;
    end
    chk("no_residual_frame", low_cnt, 0);
    push(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, w, c);
    valid_a = 1'b0;
    wait_drain(0);
    wait_drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
